ones_pattern_gen: RTL and testbench
===================================

Name: ones_pattern_gen

Overview:
Inverse of the ones counter. Given a target count k, the block enumerates every inCount-bit vector containing exactly k ones. Vectors are emitted in ascending numeric order, one per accepted handshake. Its main use is driving the ones_count family directly, in place of file stimulus, for exhaustive popcount checking.

Parameters:
inCount, 32, width of each generated vector in bits
outCount, $clog2(inCount), k is outCount+1 bits wide, which matches the ones_count count output

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request; sampled only in IDLE
k  input  outCount+1  target number of ones; sampled on accepted start
vec  output  inCount  current pattern
vec_valid  output  1  vec holds a valid pattern
vec_ready  input  1  consumer accepts vec this cycle
last  output  1  qualifies vec; this is the final pattern of the sequence
busy  output  1  high in EMIT
done  output  1  one-cycle pulse after the final pattern is accepted
err  output  1  one-cycle pulse when start is given with k > inCount

Behaviour:
- Reset: at a rst-high clock edge, state goes to IDLE and vec, vec_valid, last, busy, done and err all go to 0. rst has priority over every other input.
- Reset mid-operation: the sequence is abandoned with no done pulse. The next sequence needs a fresh start.
- States and transitions:
  - IDLE to EMIT: on start with k <= inCount.
  - IDLE to IDLE: on start with k > inCount; err pulses for 1 cycle and vec_valid stays 0.
  - EMIT to EMIT: on handshake (vec_valid && vec_ready) with last=0; vec advances to the next pattern.
  - EMIT to DONE: on handshake with last=1.
  - DONE to IDLE: unconditional after 1 cycle; done=1 during the DONE cycle.
- Latency: the first vec_valid appears on the cycle after start is sampled. After a handshake, the next pattern is valid the following cycle. Under continuous vec_ready, throughput is one pattern per cycle with no bubbles.
- Handshake rules:
  - vec and last hold stable while vec_valid && !vec_ready.
  - vec_valid never drops in EMIT until the last handshake.
- start outside IDLE is ignored. k is captured internally at start, so later changes to k have no effect.
- First pattern: (1<<k)-1, i.e. the k LSBs set.
- Next-pattern rule (Gosper), computed combinationally in one cycle:
  - c = v & -v
  - r = v + c
  - next = (((r ^ v) >> 2) >> ctz(c)) | r
  - All arithmetic is inCount bits wide; the carry out of r is discarded.
- last is asserted when vec equals ((1<<k)-1) << (inCount-k), i.e. the k MSBs set.
- Degenerate cases:
  - k=0: a single pattern, all zeros, with last=1.
  - k=inCount: a single pattern, all ones, with last=1.
  - Both take the EMIT path with a sequence length of 1.
- Sequence length is C(inCount,k). No pattern repeats and no pattern is skipped.
- Nothing is saturated or wrapped; the EMIT state always ends at the last pattern.

Decomposition:
- Shared header ones_count_defs.vh holds:
  - state encodings IDLE=2'd0, EMIT=2'd1, DONE=2'd2
  - the outCount width expression, shared with ones_count, ones_count_task and ones_count_function.
- Sub-module trailing_zero_count #(inCount): purely combinational; input in_vec [inCount-1:0], output count [outCount:0]. For zero input, count = inCount.
- All other logic (FSM, pattern register, Gosper datapath, last compare) lives in ones_pattern_gen.

Test Plan:
- inCount=8, k=2, vec_ready held 1 -> 28 patterns: 0x03, 0x05, 0x06, 0x09, 0x0A, 0x0C, 0x11 ... 0xC0. last is high only with 0xC0, done pulses 1 cycle later, and busy is high for exactly 28 cycles.
- inCount=8, k=0, then k=8 -> one pattern each: 0x00 and 0xFF, each with last=1, each followed by a done pulse.
- inCount=8, k=9 -> err pulses 1 cycle; vec_valid, busy and done stay 0; state remains IDLE.
- inCount=8, k=3, vec_ready toggling randomly -> 56 patterns, all unique and ascending. vec holds while stalled. A ones_count instance on vec reports 3 for every valid cycle.
- inCount=32, k=1 -> 32 patterns, 0x00000001 through 0x80000000, last on 0x80000000. start asserted mid-sequence is ignored.
- inCount=8, k=4: assert rst after the 10th handshake -> the next cycle shows vec_valid=0, busy=0, vec=0 and no done pulse. A fresh start with k=4 restarts at 0x0F.

Source files
------------

// File: rtl/ones_pattern_gen_pkg.sv
// ones_pattern_gen_pkg
// Shared definitions for the ones-pattern generator and its helpers:
//   - state_t     : FSM encoding (IDLE=0, EMIT=1, DONE=2), the same codes used
//                   across the ones_count family
//   - count_width : width of a ones/zeros count for a vector of 'width' bits,
//                   less one (a count is count_width(width)+1 bits wide)
package ones_pattern_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int count_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ones_pattern_gen_tzc.sv
// trailing_zero_count
// Purely combinational count of the trailing zero bits of in_vec.
// An all-zero input reports inCount.
// Ports:
//   in_vec  in   [inCount-1:0]  vector to scan
//   count   out  [outCount:0]   number of zeros below the lowest set bit
module trailing_zero_count
  import ones_pattern_gen_pkg::*;
#(
  parameter int inCount  = 32,
  parameter int outCount = count_width(inCount)
) (
  input  logic [inCount-1:0] in_vec,
  output logic [outCount:0]  count
);

  // Scan from the MSB down so the lowest set bit is the one that sticks.
  // NOTE: count is given its value before the loop so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    count = (outCount + 1)'(inCount);
    for (int i = inCount - 1; i >= 0; i--) begin
      if (in_vec[i]) count = (outCount + 1)'(i);
    end
  end

endmodule

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen
// Enumerates, in ascending numeric order, every inCount-bit vector that has
// exactly k ones, one vector per valid/ready handshake. Successors come from
// Gosper's hack computed in a single cycle.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   request a new sequence (sampled in IDLE only)
//   k          in   [outCount:0] target number of ones, captured at start
//   vec        out  [inCount-1:0] current pattern
//   vec_valid  out  vec holds a valid pattern
//   vec_ready  in   consumer accepts vec this cycle
//   last       out  vec is the final pattern (k MSBs set)
//   busy       out  high while emitting
//   done       out  one-cycle pulse after the final pattern is accepted
//   err        out  one-cycle pulse when start arrives with k > inCount
module ones_pattern_gen
  import ones_pattern_gen_pkg::*;
#(
  parameter int inCount  = 32,
  parameter int outCount = count_width(inCount)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [outCount:0]   k,
  output logic [inCount-1:0]  vec,
  output logic                vec_valid,
  input  logic                vec_ready,
  output logic                last,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [inCount-1:0] ALL_ONES = '1;
  localparam logic [outCount:0]  K_MAX    = (outCount + 1)'(inCount);

  state_t               state, state_next;
  logic [inCount-1:0]   vec_next;
  logic [outCount:0]    k_reg;
  logic                 load_k;
  logic                 err_next;
  logic                 is_last;

  // Gosper datapath
  logic [inCount-1:0]   low_bit;
  logic [inCount-1:0]   ripple;
  logic [inCount-1:0]   gosper_next;
  logic [outCount:0]    low_bit_pos;
  logic [outCount:0]    last_shift;

  trailing_zero_count #(
    .inCount (inCount),
    .outCount(outCount)
  ) u_tzc (
    .in_vec(low_bit),
    .count (low_bit_pos)
  );

  assign low_bit     = vec & (-vec);
  assign ripple      = vec + low_bit;  // carry out of the MSB is dropped
  assign gosper_next = (((ripple ^ vec) >> 2) >> low_bit_pos) | ripple;

  // Final pattern has the k MSBs set. A shift by inCount (k=0) yields zero,
  // which is exactly the single all-zeros pattern.
  assign last_shift = K_MAX - k_reg;
  assign is_last    = (vec == (ALL_ONES << last_shift));

  always_comb begin
    state_next = state;
    vec_next   = vec;
    load_k     = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (k > K_MAX) begin
            err_next = 1'b1;
          end else begin
            state_next = EMIT;
            load_k     = 1'b1;
            vec_next   = ~(ALL_ONES << k);  // k LSBs set; k=inCount gives all ones
          end
        end
      end
      EMIT: begin
        if (vec_ready) begin
          if (is_last) state_next = DONE;
          else         vec_next   = gosper_next;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values computed by the combinational block.
  // vec is cleared on reset so a consumer never sees a stale pattern after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec   <= '0;
      k_reg <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      vec   <= vec_next;
      err   <= err_next;
      if (load_k) k_reg <= k;
    end
  end

  assign vec_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign done      = (state == DONE);
  assign last      = vec_valid && is_last;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb_ones_pattern_gen
// Self-checking bench for ones_pattern_gen at inCount=8 and inCount=32.
// A queue per instance holds the full expected sequence, built by filtering
// all vectors on popcount; one negedge process compares the DUTs against it.
module tb_ones_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // inCount = 8 instance
  logic       start8, valid8, ready8, last8, busy8, done8, err8;
  logic [3:0] k8;
  logic [7:0] vec8;

  // inCount = 32 instance
  logic        start32, valid32, ready32, last32, busy32, done32, err32;
  logic [5:0]  k32;
  logic [31:0] vec32;

  ones_pattern_gen #(.inCount(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .k(k8), .vec(vec8),
    .vec_valid(valid8), .vec_ready(ready8), .last(last8),
    .busy(busy8), .done(done8), .err(err8)
  );

  ones_pattern_gen #(.inCount(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .k(k32), .vec(vec32),
    .vec_valid(valid32), .vec_ready(ready32), .last(last32),
    .busy(busy32), .done(done32), .err(err32)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] q8[$];
  logic [31:0] q32[$];
  int          cur_k8, cur_k32;
  int          hs8, hs32, busy_cnt8;
  bit          err_exp8, done_exp8, stalled8;
  bit          err_exp32, done_exp32, stalled32;
  logic [7:0]  held8;
  logic [31:0] held32;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every negedge outside reset
  always @(negedge clk) begin
    if (!rst) begin
      check("err8", err8, err_exp8);
      err_exp8 = 1'b0;
      check("done8", done8, done_exp8);
      done_exp8 = 1'b0;
      check("valid8", valid8, q8.size() > 0);
      check("busy8", busy8, q8.size() > 0);
      if (stalled8) check("hold8", vec8, held8);
      if (valid8 && q8.size() > 0) begin
        check("vec8", vec8, q8[0]);
        check("last8", last8, q8.size() == 1);
        check("ones8", $countones(vec8), cur_k8);
        if (ready8) begin
          void'(q8.pop_front());
          hs8++;
          if (q8.size() == 0) done_exp8 = 1'b1;
        end
      end else begin
        check("last8_idle", last8, 1'b0);
      end
      stalled8 = valid8 && !ready8;
      held8    = vec8;
      if (busy8) busy_cnt8++;

      check("err32", err32, err_exp32);
      err_exp32 = 1'b0;
      check("done32", done32, done_exp32);
      done_exp32 = 1'b0;
      check("valid32", valid32, q32.size() > 0);
      check("busy32", busy32, q32.size() > 0);
      if (stalled32) check("hold32", vec32, held32);
      if (valid32 && q32.size() > 0) begin
        check("vec32", vec32, q32[0]);
        check("last32", last32, q32.size() == 1);
        check("ones32", $countones(vec32), cur_k32);
        if (ready32) begin
          void'(q32.pop_front());
          hs32++;
          if (q32.size() == 0) done_exp32 = 1'b1;
        end
      end
      stalled32 = valid32 && !ready32;
      held32    = vec32;
    end
  end

  // Expected sequence: all 8-bit values with kk ones, ascending.
  task automatic load_model8(input int kk);
    logic [7:0] v;
    q8.delete();
    for (int i = 0; i < 256; i++) begin
      v = i[7:0];
      if ($countones(v) == kk) q8.push_back({24'b0, v});
    end
    cur_k8 = kk;
  endtask

  // Issue start with kk; k is scrambled afterwards to show it was captured.
  task automatic start_seq8(input int kk);
    @(posedge clk);
    #1 start8 = 1'b1;
    k8 = kk[3:0];
    @(posedge clk);
    #1 start8 = 1'b0;
    k8 = 4'd1;
    if (kk <= 8) load_model8(kk);
    else         err_exp8 = 1'b1;
  endtask

  task automatic drain8(input int budget, input bit rnd);
    int n;
    n = 0;
    while ((q8.size() > 0 || done_exp8) && n < budget) begin
      @(posedge clk);
      #1 ready8 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    check("drain8_timeout", n < budget, 1'b1);
    ready8 = 1'b1;
  endtask

  int base;

  initial begin
    rst = 1'b1;
    start8 = 1'b0; k8 = '0; ready8 = 1'b0;
    start32 = 1'b0; k32 = '0; ready32 = 1'b0;
    cur_k8 = 0; cur_k32 = 0; hs8 = 0; hs32 = 0; busy_cnt8 = 0;
    err_exp8 = 0; done_exp8 = 0; stalled8 = 0;
    err_exp32 = 0; done_exp32 = 0; stalled32 = 0;
    held8 = '0; held32 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_vec8", vec8, 8'h00);
    check("rst_valid8", valid8, 1'b0);
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_err8", err8, 1'b0);
    check("rst_vec32", vec32, 32'h0);
    check("rst_valid32", valid32, 1'b0);

    // k=2, continuous ready: 28 patterns, busy for exactly 28 cycles
    ready8 = 1'b1;
    busy_cnt8 = 0;
    start_seq8(2);
    check("model_len_k2", q8.size(), 28);
    check("model_k2_0", q8[0], 32'h03);
    check("model_k2_1", q8[1], 32'h05);
    check("model_k2_2", q8[2], 32'h06);
    check("model_k2_3", q8[3], 32'h09);
    check("model_k2_6", q8[6], 32'h11);
    check("model_k2_27", q8[27], 32'hC0);
    @(negedge clk);
    check("first_k2", vec8, 8'h03);
    drain8(100, 1'b0);
    check("busy_cycles_k2", busy_cnt8, 28);

    // Degenerate k=0 and k=8
    start_seq8(0);
    @(negedge clk);
    check("k0_vec", vec8, 8'h00);
    check("k0_last", last8, 1'b1);
    drain8(20, 1'b0);
    start_seq8(8);
    @(negedge clk);
    check("k8_vec", vec8, 8'hFF);
    check("k8_last", last8, 1'b1);
    drain8(20, 1'b0);

    // k=9 is out of range: err only
    start_seq8(9);
    @(negedge clk);
    check("k9_err", err8, 1'b1);
    check("k9_valid", valid8, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // k=3 under random back-pressure: 56 handshakes
    base = hs8;
    start_seq8(3);
    check("model_len_k3", q8.size(), 56);
    drain8(3000, 1'b1);
    check("hs_k3", hs8 - base, 56);

    // k=4 with reset after the 10th handshake
    base = hs8;
    start_seq8(4);
    begin
      int n;
      n = 0;
      while (hs8 - base < 10 && n < 100) begin
        @(posedge clk);
        #1 n++;
      end
      check("k4_wait_timeout", n < 100, 1'b1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q8.delete();
    done_exp8 = 1'b0;
    stalled8  = 1'b0;
    @(negedge clk);
    check("midrst_vec", vec8, 8'h00);
    check("midrst_valid", valid8, 1'b0);
    check("midrst_busy", busy8, 1'b0);
    start_seq8(4);
    @(negedge clk);
    check("restart_k4", vec8, 8'h0F);
    drain8(200, 1'b0);

    // inCount=32, k=1: single set bit walking up; a mid-sequence start is ignored
    @(posedge clk);
    #1 start32 = 1'b1;
    k32 = 6'd1;
    ready32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    k32 = 6'd5;
    q32.delete();
    for (int i = 0; i < 32; i++) q32.push_back(32'h1 << i);
    cur_k32 = 1;
    check("model_len_32", q32.size(), 32);
    @(negedge clk);
    check("first_32", vec32, 32'h1);
    begin
      int n;
      n = 0;
      while ((q32.size() > 0 || done_exp32) && n < 200) begin
        @(posedge clk);
        #1 start32 = (n == 5);
        n++;
      end
      check("drain32_timeout", n < 200, 1'b1);
      start32 = 1'b0;
    end
    check("hs_32", hs32, 32);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
